// File: rtl/wire_pipeline_pkg.sv
// Shared definitions for wire_pipeline: mode encoding and count-width helper.
package wire_pipeline_pkg;

  localparam int unsigned MODE_W = 1;

  typedef enum logic [MODE_W-1:0] {
    MODE_PIPE   = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  // Bits needed to hold an occupancy from 0 to depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wire_stage.sv
// One elastic pipeline slot: a data register plus its valid bit.
module wire_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             i_advance,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data only moves with a valid word so empty slots keep their last value.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/wire_pipeline.sv
// Elastic DEPTH-stage valid/ready register pipeline with a drain-then-switch
// combinational bypass mode.
module wire_pipeline
  import wire_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [WIDTH-1:0]              in_1,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_1,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          bypass,
  output logic                          mode_bypass,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          busy
);

  localparam int unsigned CW = cnt_width(DEPTH);

  mode_e            r_mode;
  mode_e            w_mode_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_cap;
  logic [DEPTH-1:0] w_adv;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_pipe;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_pipe = (r_mode == MODE_PIPE);

  // w_cap[k]: stage k's word can move on (a hole exists downstream, or the sink takes the tail).
  always_comb begin
    logic hole;
    w_cap = '0;
    hole  = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      w_cap[k] = hole;
      hole     = hole | ~w_v[k];
    end
  end

  assign w_adv = {DEPTH{w_pipe}} & (~w_v | w_cap);

  assign in_ready  = w_pipe ? (~bypass & w_adv[0]) : out_ready;
  assign out_valid = w_pipe ? w_v[DEPTH-1] : in_valid;
  assign out_1     = w_pipe ? w_d[DEPTH-1] : in_1;

  assign w_in_xfer  = w_pipe & in_valid & in_ready;
  assign w_out_xfer = w_pipe & w_v[DEPTH-1] & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_sv;
    logic [WIDTH-1:0] w_sd;

    if (k == 0) begin : g_head
      assign w_sv = w_in_xfer;
      assign w_sd = in_1;
    end else begin : g_body
      assign w_sv = w_v[k-1];
      assign w_sd = w_d[k-1];
    end

    wire_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .areset   (areset),
      .i_advance(w_adv[k]),
      .i_valid  (w_sv),
      .i_data   (w_sd),
      .o_valid  (w_v[k]),
      .o_data   (w_d[k])
    );
  end

  // Occupancy tracks transfers; it is zero whenever bypass is in effect.
  always_comb begin
    w_count_next = r_count;
    if (w_pipe) begin
      w_count_next = r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
    end else begin
      w_count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Mode register: enter bypass only once drained, leave on the next edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_mode <= MODE_PIPE;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    case (r_mode)
      MODE_PIPE: begin
        if (bypass && (w_count_next == '0)) begin
          w_mode_next = MODE_BYPASS;
        end
      end
      MODE_BYPASS: begin
        if (!bypass) begin
          w_mode_next = MODE_PIPE;
        end
      end
      default: w_mode_next = MODE_PIPE;
    endcase
  end

  assign mode_bypass = (r_mode == MODE_BYPASS);
  assign count       = r_count;
  assign busy        = (r_count != '0);

endmodule

// File: tb/tb_wire_pipeline.sv
// Randomised and directed bench for wire_pipeline against a transaction-level model.
module tb_wire_pipeline;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          areset;
  logic [W-1:0]  in_1;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_1;
  logic          out_valid;
  logic          out_ready;
  logic          bypass;
  logic          mode_bypass;
  logic [CW-1:0] count;
  logic          busy;

  wire_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .areset     (areset),
    .in_1       (in_1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_1      (out_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bypass     (bypass),
    .mode_bypass(mode_bypass),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: FIFO of words with arrival cycles; the head becomes visible at
  // max(arrival + D, previous departure + 1).
  logic [W-1:0] q_data[$];
  int           q_in[$];
  int           head_avail;
  int           last_dep;
  int           cyc;
  bit           m_mode;

  task automatic model_reset();
    q_data.delete();
    q_in.delete();
    head_avail = 0;
    last_dep   = -100;
    m_mode     = 1'b0;
  endtask

  // Called just after a falling edge: drive, check, then advance one clock.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit byp);
    bit           exp_ov;
    bit           exp_ir;
    bit           ix;
    bit           ox;
    logic [W-1:0] exp_o;
    int           exp_cnt;
    in_valid  = iv;
    in_1      = id;
    out_ready = ordy;
    bypass    = byp;
    #1;
    if (m_mode) begin
      exp_ov  = iv;
      exp_o   = id;
      exp_ir  = ordy;
      exp_cnt = 0;
    end else begin
      exp_ov  = (q_data.size() > 0) && (cyc >= head_avail);
      exp_o   = (q_data.size() > 0) ? q_data[0] : '0;
      exp_ir  = !byp && ((q_data.size() < int'(D)) || ordy);
      exp_cnt = q_data.size();
    end
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("out_1", 32'(out_1), 32'(exp_o));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("count", 32'(count), 32'(exp_cnt));
    check("busy", 32'(busy), 32'(exp_cnt != 0));
    check("mode_bypass", 32'(mode_bypass), 32'(m_mode));
    ix = iv && exp_ir;
    ox = exp_ov && ordy;
    @(posedge clk);
    if (!m_mode) begin
      if (ox) begin
        void'(q_data.pop_front());
        void'(q_in.pop_front());
        last_dep = cyc;
        if (q_in.size() > 0) head_avail = (q_in[0] + int'(D) > cyc + 1) ? q_in[0] + int'(D) : cyc + 1;
      end
      if (ix) begin
        if (q_in.size() == 0) head_avail = (cyc + int'(D) > last_dep + 1) ? cyc + int'(D) : last_dep + 1;
        q_data.push_back(id);
        q_in.push_back(cyc);
      end
      if (byp && q_data.size() == 0) m_mode = 1'b1;
    end else if (!byp) begin
      m_mode = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_1"}, 32'(out_1), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_mode"}, 32'(mode_bypass), 32'd0);
  endtask

  initial begin
    bit byp_r;
    cyc       = 0;
    areset    = 1'b1;
    in_valid  = 1'b0;
    in_1      = '0;
    out_ready = 1'b0;
    bypass    = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;

    // Streaming: three consecutive words, latency D.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure until full, then accept at full while draining.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Switch to bypass with two words in flight.
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h5A, 1'b1, 1'b1);

    // Return to pipelined mode.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Cancelled switch: one-cycle bypass pulse while a word is held.
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h67, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with two words held.
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    in_valid = 1'b0;
    bypass   = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional mode requests.
    byp_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) byp_r = ~byp_r;
      step($urandom_range(3, 0) != 0, W'($urandom), $urandom_range(2, 0) != 0, byp_r);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
